// File: rtl/mux2_arb_pkg.sv
// =============================================================================
// mux2_arb_pkg: shared types for the two-source round-robin selector arbiter.
// Revision: 1.0
// =============================================================================
`default_nettype none

package mux2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  localparam int HOLD_CNT_W = 8;

endpackage

`default_nettype wire

// File: rtl/rr_pick2.sv
// =============================================================================
// rr_pick2: combinational two-way round-robin chooser (tie goes to non-last owner).
// Revision: 1.0
// =============================================================================
`default_nettype none

module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic valid,
  output logic winner
);

  assign valid  = req0 | req1;
  assign winner = (req0 & req1) ? ~last_owner : req1;

endmodule

`default_nettype wire

// File: rtl/mux2_arbiter.sv
// =============================================================================
// mux2_arbiter: round-robin grant FSM owning the select of the shared out1 bus.
// Optional grant timeout enabled by macro GRANT_TIMEOUT_EN. Revision: 1.0
// =============================================================================
`default_nettype none

module mux2_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int W        = 3,
  parameter int MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic         req1,
  input  logic         done0,
  input  logic         done1,
  input  logic [W-1:0] data0,
  input  logic [W-1:0] data1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         sel,
  output logic [W-1:0] out1,
  output logic         busy,
  output logic         timeout
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_max_hold_check
    $error("mux2_arbiter: MAX_HOLD must be within 1..255");
  end

  state_t state;
  state_t state_next;
  logic   last_owner;
  logic   last_owner_next;
  logic   sel_next;
  logic   pick_valid;
  logic   pick_winner;
  logic   owner_done;
  logic   hold_expired;

  rr_pick2 u_pick (
    .req0       (req0),
    .req1       (req1),
    .last_owner (last_owner),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  assign gnt0       = (state == GRANT0);
  assign gnt1       = (state == GRANT1);
  assign busy       = gnt0 | gnt1;
  assign owner_done = (gnt0 & done0) | (gnt1 & done1);

`ifdef GRANT_TIMEOUT_EN
  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(MAX_HOLD - 1);

  logic [HOLD_CNT_W-1:0] hold_cnt;
  logic                  timeout_q;

  // A done arriving on the expiry cycle is a normal release, not a timeout.
  assign hold_expired = busy && (hold_cnt == HOLD_LAST) && !owner_done;
  assign timeout      = timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= hold_expired;
      if (state_next == IDLE || state_next != state) begin
        hold_cnt <= '0;
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end
`else
  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  always_comb begin
    state_next      = state;
    last_owner_next = last_owner;
    sel_next        = sel;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_next = pick_winner ? GRANT1 : GRANT0;
        end
      end
      GRANT0: begin
        // Release hands straight to a waiting peer; the owner's own req is not re-examined.
        if (done0 || hold_expired) begin
          last_owner_next = 1'b0;
          state_next      = req1 ? GRANT1 : IDLE;
        end
      end
      GRANT1: begin
        if (done1 || hold_expired) begin
          last_owner_next = 1'b1;
          state_next      = req0 ? GRANT0 : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (state_next == GRANT0) begin
      sel_next = 1'b0;
    end else if (state_next == GRANT1) begin
      sel_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      sel        <= 1'b0;
      out1       <= '0;
    end else begin
      state      <= state_next;
      last_owner <= last_owner_next;
      sel        <= sel_next;
      case (state)
        GRANT0:  out1 <= data0;
        GRANT1:  out1 <= data1;
        default: out1 <= '0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mux2_arbiter.sv
// =============================================================================
// tb_mux2_arbiter: scoreboard bench for mux2_arbiter (directed vectors).
// Revision: 1.0
// =============================================================================
`default_nettype none

module tb_mux2_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1, done0, done1;
  logic [2:0] data0, data1;
  logic       gnt0, gnt1, sel, busy, timeout;
  logic [2:0] out1;
  logic [7:0] obs;

  typedef struct {
    logic [7:0] v;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [2:0] D0A = 3'b010;
  localparam logic [2:0] D0B = 3'b110;
  localparam logic [2:0] D1  = 3'b101;

  always #5 clk = ~clk;

  mux2_arbiter #(.W(3), .MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (req0),
    .req1    (req1),
    .done0   (done0),
    .done1   (done1),
    .data0   (data0),
    .data1   (data1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .sel     (sel),
    .out1    (out1),
    .busy    (busy),
    .timeout (timeout)
  );

  assign obs = {gnt0, gnt1, sel, out1, busy, timeout};

  function automatic logic [7:0] mk(logic g0, logic g1, logic s, logic [2:0] o, logic to);
    return {g0, g1, s, o, g0 | g1, to};
  endfunction

  task automatic check(string tag, logic [7:0] act, logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %b required %b (gnt0 gnt1 sel out1[2:0] busy timeout)",
               tag, act, expv);
    end
  endtask

  task automatic step(logic r0, logic r1, logic dn0, logic dn1,
                      logic [2:0] x0, logic [2:0] x1, logic [7:0] ev, string tag);
    exp_t e;
    @(negedge clk);
    req0  = r0;
    req1  = r1;
    done0 = dn0;
    done1 = dn1;
    data0 = x0;
    data1 = x1;
    e.v   = ev;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Monitor: each pushed expectation belongs to the edge following its push.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.tag, obs, e.v);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic owner;
    rst_n = 1'b0;
    {req0, req1, done0, done1} = 4'b0;
    data0 = '0;
    data1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", obs, mk(0, 0, 0, 3'b000, 0));
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester, stray done, req dropped without done.
    step(1, 0, 0, 0, D0A, D1, mk(1, 0, 0, 3'b000, 0), "single_grant");
    step(1, 0, 0, 0, D0A, D1, mk(1, 0, 0, D0A,    0), "single_data");
    step(0, 0, 1, 0, D0A, D1, mk(0, 0, 0, D0A,    0), "single_release");
    step(0, 0, 0, 0, D0A, D1, mk(0, 0, 0, 3'b000, 0), "single_idle");
    step(1, 0, 0, 0, D0A, D1, mk(1, 0, 0, 3'b000, 0), "stray_grant");
    step(1, 0, 0, 1, D0A, D1, mk(1, 0, 0, D0A,    0), "stray_done1");
    step(0, 0, 0, 0, D0B, D1, mk(1, 0, 0, D0B,    0), "req_drop_hold");
    step(0, 0, 1, 0, D0B, D1, mk(0, 0, 0, D0B,    0), "drop_release");
    step(0, 0, 0, 0, D0B, D1, mk(0, 0, 0, 3'b000, 0), "drop_idle");

    // done and req from the same source: release first, regrant via IDLE.
    step(1, 0, 0, 0, D0B, D1, mk(1, 0, 0, 3'b000, 0), "rereq_grant");
    step(1, 0, 1, 0, D0B, D1, mk(0, 0, 0, D0B,    0), "done_and_req");
    step(1, 0, 0, 0, D0B, D1, mk(1, 0, 0, 3'b000, 0), "rereq_via_idle");
    step(0, 0, 1, 0, D0B, D1, mk(0, 0, 0, D0B,    0), "rereq_release");
    step(0, 0, 0, 0, D0B, D1, mk(0, 0, 0, 3'b000, 0), "rereq_idle");

    // Reset in the middle of a GRANT1.
    step(0, 1, 0, 0, D0B, D1, mk(0, 1, 1, 3'b000, 0), "g1_grant");
    step(0, 1, 0, 0, D0B, D1, mk(0, 1, 1, D1,     0), "g1_data");
    @(negedge clk);
    rst_n = 1'b0;
    {req0, req1, done0, done1} = 4'b0;
    #1;
    check("async_reset", obs, mk(0, 0, 0, 3'b000, 0));
    begin
      exp_t e;
      e.v   = mk(0, 0, 0, 3'b000, 0);
      e.tag = "reset_held";
      exp_q.push_back(e);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Tie straight after reset: source 0 first, then gap-free handoff.
    step(1, 1, 0, 0, D0B, D1, mk(1, 0, 0, 3'b000, 0), "tie_first0");
    step(1, 1, 1, 0, D0B, D1, mk(0, 1, 1, D0B,    0), "tie_handoff");

    // Fairness: both held, each owner releases after two cycles.
    owner = 1'b1;
    for (int h = 0; h < 8; h++) begin
      step(1, 1, 0, 0, D0B, D1,
           mk(~owner, owner, owner, owner ? D1 : D0B, 0), "fair_hold");
      step(1, 1, ~owner, owner, D0B, D1,
           mk(owner, ~owner, ~owner, owner ? D1 : D0B, 0), "fair_handoff");
      owner = ~owner;
    end
    step(0, 0, 0, 1, D0B, D1, mk(0, 0, 1, D1,     0), "release_sel_hold");
    step(0, 0, 0, 0, D0B, D1, mk(0, 0, 1, 3'b000, 0), "idle_sel_hold");

`ifdef GRANT_TIMEOUT_EN
    step(0, 1, 0, 0, D0B, D1, mk(0, 1, 1, 3'b000, 0), "to_grant");
    repeat (3) step(0, 1, 0, 0, D0B, D1, mk(0, 1, 1, D1, 0), "to_hold");
    step(0, 1, 0, 0, D0B, D1, mk(0, 0, 1, D1,     1), "to_expire");
    step(0, 0, 0, 0, D0B, D1, mk(0, 0, 1, 3'b000, 0), "to_after");
    step(0, 1, 0, 0, D0B, D1, mk(0, 1, 1, 3'b000, 0), "to2_grant");
    step(0, 1, 0, 0, D0B, D1, mk(0, 1, 1, D1,     0), "to2_hold");
    step(1, 1, 0, 0, D0B, D1, mk(0, 1, 1, D1,     0), "to2_pending");
    step(1, 1, 0, 0, D0B, D1, mk(0, 1, 1, D1,     0), "to2_pending");
    step(1, 0, 0, 0, D0B, D1, mk(1, 0, 0, D1,     1), "to2_handoff");
    step(1, 0, 0, 0, D0B, D1, mk(1, 0, 0, D0B,    0), "to2_g0_data");
    step(0, 0, 1, 0, D0B, D1, mk(0, 0, 0, D0B,    0), "to2_release");
    step(0, 0, 0, 0, D0B, D1, mk(0, 0, 0, 3'b000, 0), "to2_idle");
    step(1, 0, 0, 0, D0B, D1, mk(1, 0, 0, 3'b000, 0), "to3_grant");
    repeat (3) step(0, 0, 0, 0, D0B, D1, mk(1, 0, 0, D0B, 0), "to3_hold");
    step(0, 0, 1, 0, D0B, D1, mk(0, 0, 0, D0B,    0), "done_at_expiry");
    step(0, 0, 0, 0, D0B, D1, mk(0, 0, 0, 3'b000, 0), "to3_idle");
`else
    step(0, 1, 0, 0, D0B, D1, mk(0, 1, 1, 3'b000, 0), "long_grant");
    repeat (10) step(0, 1, 0, 0, D0B, D1, mk(0, 1, 1, D1, 0), "long_hold");
    step(0, 0, 0, 1, D0B, D1, mk(0, 0, 1, D1,     0), "long_release");
    step(0, 0, 0, 0, D0B, D1, mk(0, 0, 1, 3'b000, 0), "long_idle");
`endif

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mux2_arbiter.md
Name: mux2_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the shared 2:1 selector that feeds the 3-bit out1 bus.
- Each requester raises a request, receives a registered grant and drives its data onto out1 through the shared select until it signals done.
- Arbitration is round-robin, so neither source can starve the other.
- The block owns sel; no other logic drives the selector.

Parameters:
- W, 3, width of data0/data1/out1.
- MAX_HOLD, 8, grant timeout in cycles; used only when GRANT_TIMEOUT_EN is defined; legal range 1..255.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req0  in  1  request from source 0 (level, held until granted).
- req1  in  1  request from source 1.
- done0  in  1  single-cycle release pulse from source 0; ignored unless gnt0=1.
- done1  in  1  release pulse from source 1; ignored unless gnt1=1.
- data0  in  W  source 0 data (in1 side of the selector).
- data1  in  W  source 1 data (in2 side of the selector).
- gnt0  out  1  grant to source 0, registered.
- gnt1  out  1  grant to source 1, registered.
- sel  out  1  selector control: 0 selects data0, 1 selects data1; registered.
- out1  out  W  shared bus, registered.
- busy  out  1  high while either grant is high.
- timeout  out  1  one-cycle pulse when a grant is revoked by timeout; tied 0 without GRANT_TIMEOUT_EN.

Behaviour:
- Reset (async assert, sync release): state=IDLE, gnt0=gnt1=0, sel=0, out1=0, busy=0, timeout=0, last_owner=1 (so source 0 wins the first tie), hold counter=0.
- States: IDLE, GRANT0, GRANT1. gnt0=(state==GRANT0), gnt1=(state==GRANT1), busy=gnt0|gnt1.
- IDLE:
  - req0 only -> GRANT0.
  - req1 only -> GRANT1.
  - both -> grant goes to the source that is not last_owner.
  - none -> stay in IDLE.
- Grant latency: exactly 1 cycle from the first edge sampling req high to gnt high.
- sel updates on the same edge as the grant: 0 in GRANT0, 1 in GRANT1. sel holds its last value in IDLE.
- out1: registered every cycle. out1 <= data0 in GRANT0, data1 in GRANT1, 0 in IDLE.
  - out1 therefore lags the source data by 1 cycle.
  - The first valid out1 value appears the cycle after gnt rises.
- GRANTx:
  - done pulse from the owner -> last_owner<=x.
  - If the other requester's req is high in that same cycle, go directly to the other GRANT (no idle gap). Otherwise go to IDLE.
  - The owner's req is not re-examined on release. An immediate re-request is arbitrated normally from IDLE.
- Simultaneous done and new req from the same source in one cycle: release wins, and the request is served via IDLE next cycle.
- done from a non-owner: ignored, no state change.
- req dropped by the owner without done: the grant is kept. Only done (or timeout) releases it.
- Reset asserted mid-grant: all outputs go to reset values immediately; no partial release or timeout pulse.

Optional Feature:
- Macro GRANT_TIMEOUT_EN.
- When defined:
  - An 8-bit hold counter clears on grant entry and increments each cycle in GRANTx.
  - When it reaches MAX_HOLD-1 with no done, the grant is revoked next edge: last_owner<=x, the normal release transition is taken, and timeout pulses for 1 cycle coincident with gnt falling.
  - done in the same cycle as expiry counts as a normal release (timeout stays 0).
- When undefined: no counter, timeout tied 0, grants unbounded.

Decomposition:
- Package mux2_arb_pkg holds:
  - state enum (IDLE, GRANT0, GRANT1) as a 2-bit typedef;
  - localparam HOLD_CNT_W=8.
- One sub-module is natural: rr_pick2, a combinational round-robin chooser taking (req0, req1, last_owner) and returning (valid, winner).
- The FSM, out1 register and timeout counter stay in the top module.

Test Plan:
- Reset mid-GRANT1 (rst_n low 1 cycle) -> gnt1=0, sel=0, out1=0 asynchronously; first req0 after release is granted 1 cycle later.
- Single requester: req0=1, data0=3'b010 -> gnt0=1 and sel=0 at cycle+1, out1=3'b010 at cycle+2; done0 pulse -> IDLE, out1=0 next cycle.
- Tie from reset: req0=req1=1, data1=3'b101 -> gnt0 first; done0 -> gnt1=1 and sel=1 the next cycle with no gap; out1=3'b101 one cycle later.
- Fairness: both requests held constantly, each done after 2 cycles -> grants alternate 0,1,0,1 over 8 handoffs; neither source is granted twice in a row.
- Stray done: in GRANT0, pulse done1 -> no change; drop req0 without done0 -> gnt0 stays 1.
- GRANT_TIMEOUT_EN with MAX_HOLD=4: req1 held, no done1 -> gnt1 high exactly 4 cycles, timeout pulses once, IDLE; pending req0 granted immediately instead of IDLE.
